// File: rtl/qlogic_shift_reg_if.sv
// qlogic_shift_reg_if
// Bundles the control, data and status signals of qlogic_shift_reg so that
// the register and whatever drives it share one port.
//   master : drives S, E, MODE, SI, D and observes QZ, SO, CNT, DONE
//   slave  : the register side, the reverse of master
// Clock (QCK) and reset (R) are not part of the bundle. They stay plain ports
// on the register.
interface qlogic_shift_reg_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             S;
  logic             E;
  logic [1:0]       MODE;
  logic             SI;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] QZ;
  logic             SO;
  logic [CW-1:0]    CNT;
  logic             DONE;

  modport master (
    output S, E, MODE, SI, D,
    input  QZ, SO, CNT, DONE
  );

  modport slave (
    input  S, E, MODE, SI, D,
    output QZ, SO, CNT, DONE
  );
endinterface

// File: rtl/qlogic_shift_reg.sv
// qlogic_shift_reg
// This is the WIDTH-bit form of the set/enable/reset flip-flop cell. It can
// hold, load in parallel, or shift left or right with a serial input and
// output. A saturating shift counter and a DONE flag are included so that
// serialiser and deserialiser chains can map onto one cell.
//   QCK       : clock. Every state change happens on its rising edge.
//   R         : synchronous reset, active-high. Has the highest priority.
//   bus.S     : synchronous set to all ones. Sits below R in priority.
//   bus.E     : enables the MODE operation.
//   bus.MODE  : 00 hold, 01 load, 10 shift left, 11 shift right.
//   bus.SI    : serial input bit.
//   bus.D     : parallel load data.
//   bus.QZ    : register contents.
//   bus.SO    : registered copy of the bit pushed out by the last shift.
//   bus.CNT   : number of shifts since the last load, set or reset.
//               It saturates at WIDTH.
//   bus.DONE  : CNT == WIDTH.
module qlogic_shift_reg #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
  input  logic               QCK,
  input  logic               R,
  qlogic_shift_reg_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  // Declaration initialisers give the simulation power-up state. On targets
  // that cannot preset flops, only the reset value applies.
  logic [WIDTH-1:0] qz_r  = INIT;
  logic             so_r  = 1'b0;
  logic [CW-1:0]    cnt_r = '0;

  logic [CW-1:0]    cnt_step;

  // The counter advances on a shift in either direction and stops at WIDTH.
  assign cnt_step = (cnt_r < CNT_MAX) ? cnt_r + 1'b1 : cnt_r;

  always_ff @(posedge QCK) begin
    if (R) begin
      qz_r  <= INIT;
      so_r  <= 1'b0;
      cnt_r <= '0;
    end else if (bus.S) begin
      qz_r  <= {WIDTH{1'b1}};
      so_r  <= 1'b0;
      cnt_r <= '0;
    end else if (bus.E) begin
      case (bus.MODE)
        2'b00: begin
        end
        2'b01: begin
          qz_r  <= bus.D;
          cnt_r <= '0;
        end
        2'b10: begin
          qz_r  <= {qz_r[WIDTH-2:0], bus.SI};
          so_r  <= qz_r[WIDTH-1];
          cnt_r <= cnt_step;
        end
        2'b11: begin
          qz_r  <= {bus.SI, qz_r[WIDTH-1:1]};
          so_r  <= qz_r[0];
          cnt_r <= cnt_step;
        end
        // An unknown MODE can only reach this branch in a four-state
        // simulator. There the state goes to X so the bad control is visible.
        default: begin
          qz_r  <= 'x;
          so_r  <= 1'bx;
          cnt_r <= 'x;
        end
      endcase
    end
  end

  assign bus.QZ   = qz_r;
  assign bus.SO   = so_r;
  assign bus.CNT  = cnt_r;
  assign bus.DONE = (cnt_r == CNT_MAX);

endmodule

// File: tb/tb_qlogic_shift_reg.sv
// tb_qlogic_shift_reg
// Bench with directed vectors and a scoreboard for qlogic_shift_reg
// (WIDTH=8). Two instances share the stimulus. dut0 uses INIT=8'h00 and
// dut1 uses INIT=8'h3C. Each vector is applied on the falling edge, and the
// expected post-edge state is pushed into a queue at the same time. A
// separate monitor pops those entries 1 ns after each rising edge and
// compares them with the selected instance.
module tb_qlogic_shift_reg;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  qlogic_shift_reg_if #(.WIDTH(WIDTH)) if0 ();
  qlogic_shift_reg_if #(.WIDTH(WIDTH)) if1 ();

  qlogic_shift_reg #(.WIDTH(WIDTH), .INIT(8'h00)) dut0 (
    .QCK (clk),
    .R   (rst),
    .bus (if0.slave)
  );

  qlogic_shift_reg #(.WIDTH(WIDTH), .INIT(8'h3C)) dut1 (
    .QCK (clk),
    .R   (rst),
    .bus (if1.slave)
  );

  typedef struct {
    int            which;
    string         name;
    logic [7:0]    qz;
    logic          so;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Monitor: compares everything queued for the edge that has just occurred.
  initial begin
    exp_t       e;
    logic [7:0] a_qz;
    logic       a_so;
    logic [CW-1:0] a_cnt;
    logic       a_done;
    logic       x_done;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.which == 0) begin
          a_qz = if0.QZ; a_so = if0.SO; a_cnt = if0.CNT; a_done = if0.DONE;
        end else begin
          a_qz = if1.QZ; a_so = if1.SO; a_cnt = if1.CNT; a_done = if1.DONE;
        end
        x_done = (e.cnt == CW'(WIDTH));
        checks++;
        if (a_qz !== e.qz) begin
          errors++;
          $display("FAIL %s dut%0d QZ: got %h, expected %h", e.name, e.which, a_qz, e.qz);
        end
        checks++;
        if (a_so !== e.so) begin
          errors++;
          $display("FAIL %s dut%0d SO: got %b, expected %b", e.name, e.which, a_so, e.so);
        end
        checks++;
        if (a_cnt !== e.cnt) begin
          errors++;
          $display("FAIL %s dut%0d CNT: got %0d, expected %0d", e.name, e.which, a_cnt, e.cnt);
        end
        checks++;
        if (a_done !== x_done) begin
          errors++;
          $display("FAIL %s dut%0d DONE: got %b, expected %b", e.name, e.which, a_done, x_done);
        end
      end
    end
  end

  // Applies one vector to both instances on the falling edge.
  task automatic drive(input logic r, input logic s, input logic e,
                       input logic [1:0] mode, input logic si, input logic [7:0] d);
    @(negedge clk);
    rst      = r;
    if0.S    = s;    if1.S    = s;
    if0.E    = e;    if1.E    = e;
    if0.MODE = mode; if1.MODE = mode;
    if0.SI   = si;   if1.SI   = si;
    if0.D    = d;    if1.D    = d;
  endtask

  task automatic expect_state(input int which, input string name,
                              input logic [7:0] qz, input logic so, input int cnt);
    exp_t e;
    e.which = which;
    e.name  = name;
    e.qz    = qz;
    e.so    = so;
    e.cnt   = CW'(cnt);
    sb.push_back(e);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00);

    // Some activity first, then a reset.
    drive(0, 1, 0, 2'b00, 0, 8'h00); expect_state(0, "set_pre",   8'hFF, 0, 0);
    drive(0, 0, 1, 2'b01, 0, 8'h33); expect_state(0, "load_pre",  8'h33, 0, 0);
    drive(0, 0, 1, 2'b10, 1, 8'h00); expect_state(0, "shl_pre",   8'h67, 0, 1);
    drive(1, 0, 1, 2'b10, 1, 8'hEE); expect_state(0, "reset",     8'h00, 0, 0);
                                     expect_state(1, "reset_init", 8'h3C, 0, 0);

    // Load, then three left shifts.
    drive(0, 0, 1, 2'b01, 0, 8'hA5); expect_state(0, "load_a5",   8'hA5, 0, 0);
    drive(0, 0, 1, 2'b10, 1, 8'h00); expect_state(0, "shl_1",     8'h4B, 1, 1);
    drive(0, 0, 1, 2'b10, 0, 8'h00); expect_state(0, "shl_2",     8'h96, 0, 2);
    drive(0, 0, 1, 2'b10, 1, 8'h00); expect_state(0, "shl_3",     8'h2D, 1, 3);

    // Set, then nine right shifts. The counter saturates at 8.
    drive(0, 1, 0, 2'b00, 0, 8'h00); expect_state(0, "set",       8'hFF, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      logic [7:0] ones;
      ones = 8'hFF;
      drive(0, 0, 1, 2'b11, 0, 8'h00);
      expect_state(0, $sformatf("shr_sat_%0d", k), ones >> k, (k <= 8), (k < 8) ? k : 8);
    end

    // Enable gating with QZ=5A and CNT=2.
    drive(0, 0, 1, 2'b01, 0, 8'h96); expect_state(0, "load_96",   8'h96, 0, 0);
    drive(0, 0, 1, 2'b10, 1, 8'h00); expect_state(0, "gate_shl1", 8'h2D, 1, 1);
    drive(0, 0, 1, 2'b10, 0, 8'h00); expect_state(0, "gate_shl2", 8'h5A, 0, 2);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 2'b10, 1, 8'hFF);
      expect_state(0, $sformatf("gate_off_%0d", k), 8'h5A, 0, 2);
    end
    drive(0, 0, 1, 2'b00, 1, 8'hFF); expect_state(0, "mode_hold", 8'h5A, 0, 2);

    // Priority checks.
    drive(1, 1, 1, 2'b01, 0, 8'h12); expect_state(0, "r_over_s",  8'h00, 0, 0);
                                     expect_state(1, "r_over_s",  8'h3C, 0, 0);
    drive(0, 1, 1, 2'b01, 0, 8'h12); expect_state(0, "s_over_e",  8'hFF, 0, 0);
                                     expect_state(1, "s_over_e",  8'hFF, 0, 0);

    // Change of shift direction.
    drive(0, 0, 1, 2'b01, 0, 8'h81); expect_state(0, "load_81",   8'h81, 0, 0);
    drive(0, 0, 1, 2'b10, 0, 8'h00); expect_state(0, "dir_shl",   8'h02, 1, 1);
    drive(0, 0, 1, 2'b11, 1, 8'h00); expect_state(0, "dir_shr",   8'h81, 0, 2);

    // Reset in the middle of a sequence. The next shift counts from 1.
    drive(1, 0, 1, 2'b10, 1, 8'h00); expect_state(0, "mid_reset", 8'h00, 0, 0);
    drive(0, 0, 1, 2'b10, 1, 8'h00); expect_state(0, "post_rst",  8'h01, 0, 1);

    drive(0, 0, 0, 2'b00, 0, 8'h00);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
